// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader.
// Holds the reader FSM state encoding and the output buffer depth.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO-ordered skid buffer with valid/ready output.
// Ports: push_i/push_data_i capture, pop_i consumes head,
// data_o/valid_o present head, occ_o reports occupancy.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [1:0]       occ_o
);

   localparam logic [1:0] FULL = 2'(BUF_DEPTH);

   logic [WIDTH-1:0] ent0_q, ent0_d;
   logic [WIDTH-1:0] ent1_q, ent1_d;
   logic [1:0]       occ_q, occ_d;
   logic             pop_ok, push_ok;

   assign pop_ok  = pop_i && (occ_q != 2'd0);
   assign push_ok = push_i && ((occ_q < FULL) || pop_ok);

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      case ({push_ok, pop_ok})
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b10: begin
            if (occ_q == 2'd0) ent0_d = push_data_i;
            else               ent1_d = push_data_i;
            occ_d = occ_q + 2'd1;
         end
         2'b11: begin
            // Head leaves; new word lands behind whatever remains.
            if (occ_q == 2'd1) begin
               ent0_d = push_data_i;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= '0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign data_o  = ent0_q;
   assign valid_o = (occ_q != 2'd0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller between a synchronous FIFO and a stream sink.
// Ports: fifo_* FIFO read side, m_* valid/ready stream, burst_* pulses,
// err_underflow sticky flag. Optional idle flush: FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 4,
   parameter int TIMEOUT   = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fifo_rd,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   input  logic             fifo_threshold,
   input  logic             fifo_underflow,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             burst_start,
   output logic             burst_done,
   output logic             err_underflow
);

   localparam logic [CNT_W-1:0] BLEN = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inflight_q;
   logic             err_q;
   logic [1:0]       occ;
   logic [2:0]       pend;
   logic             pop, room, flush, start;

   // Read data arrives the cycle after fifo_rd and is pushed then.
   rd_skid_buf #(.WIDTH(WIDTH)) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (fifo_data),
      .pop_i       (pop),
      .data_o      (m_data),
      .valid_o     (m_valid),
      .occ_o       (occ)
   );

   assign pop   = m_valid & m_ready;
   // Slots committed after this cycle's pop; keep below 2 to issue.
   assign pend  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
   assign room  = (pend < 3'd2);
   assign start = fifo_threshold | flush;

`ifdef FIFO_RD_TIMEOUT_EN
   logic [CNT_W-1:0] tmo_q, tmo_d;

   assign flush = (tmo_q == TMO);

   always_comb begin
      tmo_d = '0;
      if (state_q == IDLE && !fifo_empty && !fifo_threshold && !flush)
         tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   logic unused_tmo;

   assign flush      = 1'b0;
   assign unused_tmo = |TMO;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inflight_q <= fifo_rd;
         err_q      <= err_q | fifo_underflow;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (1'b1)
         (state_q == IDLE): begin
            if (start) begin
               state_d = BURST;
               cnt_d   = '0;
            end
         end
         (state_q == BURST): begin
            if (fifo_rd) cnt_d = cnt_q + 1'b1;
            if (cnt_d == BLEN || (fifo_empty && !fifo_rd))
               state_d = DRAIN;
         end
         (state_q == DRAIN): begin
            if (occ == 2'd0 && !inflight_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_rd     = 1'b0;
      burst_start = 1'b0;
      burst_done  = 1'b0;
      if (state_q == BURST) begin
         fifo_rd     = !fifo_empty && (cnt_q < BLEN) && room;
         burst_start = fifo_rd && (cnt_q == '0);
      end
      if (state_q == DRAIN)
         burst_done = (occ == 2'd0) && !inflight_q;
   end

   assign err_underflow = err_q;

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Consumer-side controller for the synchronous FIFO. It watches the FIFO status flags and issues burst reads of `fifo_rd`. Read data is captured into a 2-entry output buffer and presented downstream on a valid/ready stream. It sits between the FIFO read port and any streaming sink, and guarantees the FIFO is never read while empty.

## Interface
- `WIDTH`, 8, data width; must match the FIFO data width.
- `BURST_LEN`, 8, maximum reads per burst; must be ≤ the FIFO threshold level.
- `CNT_W`, 4, width of the burst and timeout counters; must satisfy 2^CNT_W > max(BURST_LEN, TIMEOUT).
- `TIMEOUT`, 15, idle cycles with FIFO non-empty before a flush burst starts.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fifo_rd` out 1: read strobe to the FIFO.
- `fifo_data` in WIDTH: FIFO `data_out`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_threshold` in 1: FIFO threshold flag.
- `fifo_underflow` in 1: FIFO underflow flag.
- `m_data` out WIDTH: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `burst_start` out 1: one-cycle pulse on the first read of a burst.
- `burst_done` out 1: one-cycle pulse when a burst is fully delivered.
- `err_underflow` out 1: sticky underflow error.

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE → BURST when `fifo_threshold`=1, or when a flush fires (see Configuration). The burst counter clears on this transition.
- BURST behaviour:
  - `fifo_rd`=1 when all of the following hold: `fifo_empty`=0, burst count < BURST_LEN, and (buffer occupancy + reads in flight − pop this cycle) < 2.
  - Each read increments the burst count.
- BURST → DRAIN when either:
  - the burst count reaches BURST_LEN, or
  - `fifo_empty`=1 with no read issued this cycle (partial burst).
- DRAIN → IDLE when the buffer is empty and no read is in flight. `burst_done` pulses in that cycle.
- The output buffer is a FIFO-ordered 2-entry skid. A push and a pop in the same cycle are both honoured. Data order is preserved.
- `fifo_rd` is never asserted while `fifo_empty`=1.
- `err_underflow` sets on any cycle with `fifo_underflow`=1 and clears only on reset.
- While `m_valid`=1 and `m_ready`=0, `m_data` must remain stable.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = IDLE, counters = 0, buffer empty.
  - `fifo_rd`, `m_valid`, `burst_start`, `burst_done`, `err_underflow` = 0.
  - `m_data` = 0.
- The FIFO read is registered. For `fifo_rd` high in cycle N:
  - `fifo_data` is valid in N+1 and is captured at the end of N+1.
  - `m_valid` rises in N+2.
- With `m_ready`=1 throughout, reads are back-to-back at 1 per cycle for up to BURST_LEN cycles.
- `burst_start` is coincident with the first `fifo_rd` of the burst.
- Reset asserted mid-burst drops all state immediately. Data held in the buffer or in flight is discarded.
- The flags are sampled every cycle. Threshold re-asserting in DRAIN has no effect until the FSM reaches IDLE.

## Configuration
- `FIFO_RD_TIMEOUT_EN` defined:
  - In IDLE, a timeout counter increments each cycle while `fifo_empty`=0 and `fifo_threshold`=0.
  - It clears when the FIFO is empty or a burst starts.
  - When the counter reaches TIMEOUT, a flush burst starts with the same rules as a threshold burst.
- `FIFO_RD_TIMEOUT_EN` undefined: the timeout counter is absent, only threshold starts a burst, and TIMEOUT is unused.

## Structure
- `fifo_rd_pkg` holds the state enum (IDLE, BURST, DRAIN) and the buffer depth constant (2).
- One sub-module, `rd_skid_buf`: the 2-entry valid/ready buffer with push, pop, and occupancy output.

## Test plan
All scenarios use FIFO model parameters WIDTH=8, depth 16, threshold 8.
1. Write 0x00–0x07 with `m_ready`=1 → `fifo_rd` high for 8 consecutive cycles; `burst_start` pulses on the first; `m_data` = 0x00..0x07 starting 2 cycles after the first `fifo_rd`; `burst_done` pulses once.
2. Same data, `m_ready`=0 for 10 cycles, then 1 → only 2 reads issued before stalling; `m_data` holds 0x00; the full sequence 0x00–0x07 is delivered with no loss or duplication.
3. With the macro: write 3 bytes (0xA0–0xA2), no threshold → after 15 idle cycles a 3-read burst outputs 0xA0–0xA2. Without the macro, no `fifo_rd` is issued.
4. Force `fifo_threshold`=1 with 5 entries → 5 reads; `fifo_rd` is never high while `fifo_empty`=1; `burst_done` pulses; `err_underflow` stays 0.
5. Assert `rst_n`=0 on the 4th read of a burst → all outputs read 0 in the same cycle; after release, the FSM starts from IDLE.
6. Pulse `fifo_underflow` for 1 cycle → `err_underflow` goes to 1, stays 1 through later bursts, and clears only on reset.
